da_coeff_loader: RTL and testbench
==================================

// Module: da_coeff_loader
// PURPOSE
//  Drives the DA coefficient-load port (CIN/CADDR/CLOAD) of the FIR filter. It accepts 64 signed taps over a
//  valid/ready stream and expands each group of 8 taps into a 256-entry DA LUT of partial sums. It sits
//  between the host/config path and the da block, on the same clock as the filter datapath.
// PARAMETERS
//  COEF_W   16  tap coefficient width, signed two's complement
//  LUT_W    20  LUT entry width; must be >= COEF_W+3
//  NUM_GRP  8   LUT groups (one per DA address bus A0..A7); fixes CADDR[10:8]
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  start       in   1       begin new load; pulse
//  coef_in     in   COEF_W  tap value, taps in order 0..63
//  coef_valid  in   1       coef_in valid
//  coef_ready  out  1       loader accepts coef_in
//  CIN         out  LUT_W   LUT entry data to da
//  CADDR       out  11      {group[2:0], entry[7:0]}
//  CLOAD       out  1       write strobe, one entry per cycle
//  busy        out  1       high in COLLECT or WRITE
//  load_done   out  1       one-cycle pulse after last entry of group 7 written
//  lut_valid   out  1       high from load_done until next start
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, group=0, tap=0, entry=0, coefficient regs 0.
//  - States: IDLE, COLLECT, WRITE, DONE. All outputs registered.
//  - IDLE/DONE: start -> COLLECT, group=0, tap=0, lut_valid<=0. DONE lasts 1 cycle (load_done=1) -> IDLE.
//  - COLLECT: coef_ready=1. On coef_valid&coef_ready store coef_in in reg[tap[2:0]], tap++.
//    Handshake on tap[2:0]==7 -> WRITE, entry=0; coef_ready drops the cycle after that handshake.
//  - WRITE: coef_ready=0; coef_valid ignored. Entries 0..255 emitted on 256 consecutive cycles;
//    first CLOAD=1 the cycle after entering WRITE. CADDR={group,entry}.
//    CIN = sum over b=0..7 of (entry[b] ? sext(reg[b]) : 0), full-precision to LUT_W; entry 0 -> CIN=0.
//  - After entry 255: group==7 -> DONE (lut_valid<=1); else group++ -> COLLECT. CLOAD=0 outside WRITE.
//  - Full load: 64 handshakes + 2048 CLOAD cycles; no gaps within a group's 256 writes.
//  - start during COLLECT/WRITE: abort, restart at group 0/tap 0/COLLECT; CLOAD=0 from next cycle;
//    start wins over a same-cycle coefficient handshake (that coefficient is dropped).
//  - reset mid-load: immediate return to reset values; lut_valid=0; partially written LUT is invalid.
//  - CADDR/CIN hold last value when CLOAD=0.
// CONFIGURATION
//  - Macro LUT_CHECKSUM_EN: adds output lut_csum [23:0] = sum mod 2^24 of every CIN written with CLOAD=1
//    since the last start; cleared on reset and on start; stable once load_done pulses.
//  - Without LUT_CHECKSUM_EN: port and accumulator absent; all other behaviour identical.
// STRUCTURE
//  - Shared package fir_pkg: COEF_W, LUT_W, NUM_GRP, CADDR_W=11, state encoding localparams.
//  - One sub-module da_lut_sum: combinational masked 8-input adder tree (reg[7:0] x entry -> CIN).
//  - FSM, counters, coefficient regs, output regs in da_coeff_loader.
// TESTING
//  1. All 64 taps = 1 -> every group: CIN(0x00)=0, CIN(0x0F)=4, CIN(0xFF)=8; 2048 CLOAD pulses, 1 load_done.
//  2. Tap0=-32768, others 0 -> odd entries of group 0 CIN=0xF8000, even=0; groups 1..7 all 0.
//  3. All taps=0x7FFF -> CIN(0xFF)=0x3FFF8; all taps=0x8000 -> CIN(0xFF)=0xC0000 (no overflow).
//  4. Taps 0..63 = index value -> CADDR at group 5 entry 0x03 = 0x503, CIN=40+41=81.
//  5. coef_valid held high with gaps/backpressure; start mid-WRITE of group 2 -> CLOAD low next cycle,
//     coef_ready high, reload from tap 0 completes normally; reset mid-load -> all outputs 0.
//  6. LUT_CHECKSUM_EN, all taps=1 -> lut_csum=0x002000 at load_done; cleared to 0 on next start.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths, state encoding and sign-extension helper for the DA coefficient loader.
package fir_pkg;

  localparam int COEF_W       = 16;
  localparam int LUT_W        = 20;
  localparam int NUM_GRP      = 8;
  localparam int CADDR_W      = 11;
  localparam int GRP_W        = 3;
  localparam int ENTRY_W      = 8;
  localparam int TAPS_PER_GRP = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_WRITE   = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  function automatic logic [LUT_W-1:0] sext_coef(input logic [COEF_W-1:0] c);
    return {{(LUT_W-COEF_W){c[COEF_W-1]}}, c};
  endfunction

endpackage

// File: rtl/da_lut_sum.sv
// Combinational DA partial-sum: adds the sign-extended taps selected by the set bits of entry_i.
module da_lut_sum
  import fir_pkg::*;
(
  input  logic [TAPS_PER_GRP*COEF_W-1:0] coefs_i,
  input  logic [ENTRY_W-1:0]             entry_i,
  output logic [LUT_W-1:0]               sum_o
);

  logic [LUT_W-1:0] term_s [TAPS_PER_GRP];
  logic [LUT_W-1:0] l1_s [4];
  logic [LUT_W-1:0] l2_s [2];

  // Mask each tap by its entry bit, then reduce through a balanced 8->4->2->1 tree
  always_comb begin
    for (int b = 0; b < TAPS_PER_GRP; b++) begin
      term_s[b] = entry_i[b] ? sext_coef(coefs_i[b*COEF_W +: COEF_W]) : '0;
    end
    for (int i = 0; i < 4; i++) begin
      l1_s[i] = term_s[2*i] + term_s[2*i+1];
    end
    for (int i = 0; i < 2; i++) begin
      l2_s[i] = l1_s[2*i] + l1_s[2*i+1];
    end
    sum_o = l2_s[0] + l2_s[1];
  end

endmodule

// File: rtl/da_coeff_loader.sv
// Collects 64 taps over valid/ready and writes each 8-tap group as a 256-entry DA LUT.
// Optional macro LUT_CHECKSUM_EN adds a running 24-bit sum of written entries on lut_csum.
module da_coeff_loader
  import fir_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COEF_W-1:0]  coef_in,
  input  logic               coef_valid,
  output logic               coef_ready,
  output logic [LUT_W-1:0]   CIN,
  output logic [CADDR_W-1:0] CADDR,
  output logic               CLOAD,
  output logic               busy,
  output logic               load_done,
  output logic               lut_valid
`ifdef LUT_CHECKSUM_EN
  ,
  output logic [23:0]        lut_csum
`endif
);

  localparam logic [ENTRY_W-1:0] LAST_ENTRY = {ENTRY_W{1'b1}};
  localparam logic [GRP_W-1:0]   LAST_GRP   = GRP_W'(NUM_GRP-1);
  localparam logic [2:0]         LAST_TAP   = 3'd7;

  state_t                         state_q, state_d;
  logic [5:0]                     tap_q, tap_d;
  logic [GRP_W-1:0]               group_q, group_d;
  logic [ENTRY_W-1:0]             entry_q, entry_d;
  logic [TAPS_PER_GRP*COEF_W-1:0] coef_q, coef_d;
  logic                           coef_ready_q, coef_ready_d;
  logic                           cload_q, cload_d;
  logic                           busy_q, busy_d;
  logic                           load_done_q, load_done_d;
  logic                           lut_valid_q, lut_valid_d;
  logic [LUT_W-1:0]               cin_q, cin_d;
  logic [CADDR_W-1:0]             caddr_q, caddr_d;
  logic [LUT_W-1:0]               lut_sum_s;
  logic                           hs_s;

  // start takes priority, so a coefficient offered in the same cycle is dropped
  assign hs_s = coef_ready_q && coef_valid && !start;

  da_lut_sum u_lut_sum (
    .coefs_i (coef_q),
    .entry_i (entry_q),
    .sum_o   (lut_sum_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_COLLECT;
        else       state_d = ST_IDLE;
      end
      ST_COLLECT: begin
        if (start)                                 state_d = ST_COLLECT;
        else if (hs_s && tap_q[2:0] == LAST_TAP)   state_d = ST_WRITE;
        else                                       state_d = ST_COLLECT;
      end
      ST_WRITE: begin
        if (start)                      state_d = ST_COLLECT;
        else if (entry_q == LAST_ENTRY) state_d = (group_q == LAST_GRP) ? ST_DONE : ST_COLLECT;
        else                            state_d = ST_WRITE;
      end
      ST_DONE: begin
        if (start) state_d = ST_COLLECT;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tap_d   = tap_q;
    group_d = group_q;
    entry_d = entry_q;
    coef_d  = coef_q;
    if (start) begin
      tap_d   = '0;
      group_d = '0;
      entry_d = '0;
    end else if (hs_s) begin
      coef_d[tap_q[2:0]*COEF_W +: COEF_W] = coef_in;
      tap_d   = tap_q + 6'd1;
      entry_d = '0;
    end else if (state_q == ST_WRITE) begin
      entry_d = entry_q + 8'd1;
      if (entry_q == LAST_ENTRY) group_d = group_q + 3'd1;
      else                       group_d = group_q;
    end else begin
      tap_d = tap_q;
    end
  end

  // Outputs are registered one cycle behind the entry counter
  always_comb begin
    coef_ready_d = (state_d == ST_COLLECT);
    busy_d       = (state_d == ST_COLLECT) || (state_d == ST_WRITE);
    cload_d      = (state_q == ST_WRITE) && !start;
    load_done_d  = (state_q == ST_DONE);
    if (cload_d) begin
      caddr_d = {group_q, entry_q};
      cin_d   = lut_sum_s;
    end else begin
      caddr_d = caddr_q;
      cin_d   = cin_q;
    end
    if (start)                  lut_valid_d = 1'b0;
    else if (state_q == ST_DONE) lut_valid_d = 1'b1;
    else                        lut_valid_d = lut_valid_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_q        <= '0;
      group_q      <= '0;
      entry_q      <= '0;
      coef_q       <= '0;
      coef_ready_q <= 1'b0;
      cload_q      <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      lut_valid_q  <= 1'b0;
      cin_q        <= '0;
      caddr_q      <= '0;
    end else begin
      tap_q        <= tap_d;
      group_q      <= group_d;
      entry_q      <= entry_d;
      coef_q       <= coef_d;
      coef_ready_q <= coef_ready_d;
      cload_q      <= cload_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      lut_valid_q  <= lut_valid_d;
      cin_q        <= cin_d;
      caddr_q      <= caddr_d;
    end
  end

  assign coef_ready = coef_ready_q;
  assign CLOAD      = cload_q;
  assign CADDR      = caddr_q;
  assign CIN        = cin_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign lut_valid  = lut_valid_q;

`ifdef LUT_CHECKSUM_EN
  logic [23:0] csum_q, csum_d;

  // Sum of the entries being written, restarted by every start
  always_comb begin
    if (start)        csum_d = 24'd0;
    else if (cload_d) csum_d = csum_q + {{(24-LUT_W){1'b0}}, cin_d};
    else              csum_d = csum_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= 24'd0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign lut_csum = csum_q;
`endif

endmodule

// File: tb/tb_da_coeff_loader.sv
// Randomized bench for da_coeff_loader against a tap-level reference of the expected LUT contents.
module tb_da_coeff_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] coef_in;
  logic        coef_valid;
  logic        coef_ready;
  logic [19:0] CIN;
  logic [10:0] CADDR;
  logic        CLOAD;
  logic        busy;
  logic        load_done;
  logic        lut_valid;
`ifdef LUT_CHECKSUM_EN
  logic [23:0] lut_csum;
`endif

  da_coeff_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .CIN        (CIN),
    .CADDR      (CADDR),
    .CLOAD      (CLOAD),
    .busy       (busy),
    .load_done  (load_done),
    .lut_valid  (lut_valid)
`ifdef LUT_CHECKSUM_EN
    ,
    .lut_csum   (lut_csum)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ld_cnt = 0;
  int          q_base = 0;
  int          ld_base = 0;
  logic [15:0] cur_taps [64];
  logic [10:0] q_addr [$];
  logic [19:0] q_cin [$];
  int          q_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every LUT write with its cycle number
  always @(negedge clk) begin
    if (CLOAD) begin
      q_addr.push_back(CADDR);
      q_cin.push_back(CIN);
      q_cyc.push_back(cyc);
    end
    if (load_done) ld_cnt <= ld_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Expected LUT word: signed sum of the group's taps picked by the entry bits, kept to 20 bits
  function automatic logic [19:0] exp_cin(input int idx);
    int s = 0;
    int g = idx / 256;
    int e = idx % 256;
    for (int b = 0; b < 8; b++) begin
      if (((e >> b) & 1) == 1) s += int'($signed(cur_taps[g*8+b]));
    end
    return s[19:0];
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    q_base  = q_addr.size();
    ld_base = ld_cnt;
    check_val("ready_after_start", 32'(coef_ready), 32'd1);
    check_val("busy_after_start", 32'(busy), 32'd1);
    check_val("lut_valid_cleared", 32'(lut_valid), 32'd0);
`ifdef LUT_CHECKSUM_EN
    check_val("csum_cleared", 32'(lut_csum), 32'd0);
`endif
  endtask

  task automatic feed(input int n, input int gap_pct);
    int  i = 0;
    int  guard = 0;
    bit  hs;
    while (i < n && guard < 20000) begin
      coef_valid = ($urandom_range(99) >= gap_pct);
      coef_in    = cur_taps[i];
      @(negedge clk);
      hs = coef_valid && coef_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    coef_valid = 1'b0;
    check_val("feed_complete", 32'(i), 32'(n));
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (load_done) begin
        seen = 1'b1;
        check_val("lut_valid_at_done", 32'(lut_valid), 32'd1);
        check_val("busy_at_done", 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
    end
    check_val("load_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check_val("done_one_cycle", 32'(load_done), 32'd0);
    check_val("cload_after_done", 32'(CLOAD), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic verify_load();
    int          n = q_addr.size() - q_base;
    int          gaps;
    logic [23:0] sum = 24'd0;
    check_val("write_count", 32'(n), 32'd2048);
    check_val("done_count", 32'(ld_cnt - ld_base), 32'd1);
    for (int i = 0; i < 2048 && i < n; i++) begin
      check_val("caddr", 32'(q_addr[q_base+i]), 32'(i));
      check_val("cin", 32'(q_cin[q_base+i]), 32'(exp_cin(i)));
      sum = sum + {4'd0, exp_cin(i)};
    end
    for (int g = 0; g < 8; g++) begin
      gaps = 0;
      for (int e = 1; e < 256; e++) begin
        if (g*256+e < n && q_cyc[q_base+g*256+e] - q_cyc[q_base+g*256+e-1] != 1) gaps++;
      end
      check_val("group_contiguous", 32'(gaps), 32'd0);
    end
`ifdef LUT_CHECKSUM_EN
    check_val("lut_csum", 32'(lut_csum), 32'(sum));
`endif
  endtask

  task automatic run_load(input int gap_pct);
    pulse_start();
    feed(64, gap_pct);
    wait_done(400);
    verify_load();
  endtask

  task automatic wait_write(input logic [10:0] addr, input logic grp_only, output bit found);
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (CLOAD && (grp_only ? (CADDR[10:8] == addr[10:8]) : (CADDR == addr))) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check_val("write_point_reached", 32'(found), 32'd1);
  endtask

  task automatic rand_taps();
    for (int i = 0; i < 64; i++) cur_taps[i] = 16'($urandom);
  endtask

  initial begin
    bit found;
    reset      = 1'b1;
    start      = 1'b0;
    coef_valid = 1'b0;
    coef_in    = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_coef_ready", 32'(coef_ready), 32'd0);
    check_val("rst_cload", 32'(CLOAD), 32'd0);
    check_val("rst_cin", 32'(CIN), 32'd0);
    check_val("rst_caddr", 32'(CADDR), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_load_done", 32'(load_done), 32'd0);
    check_val("rst_lut_valid", 32'(lut_valid), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) cur_taps[i] = 16'd1;
    run_load(0);
    check_val("ones_cin_00", 32'(q_cin[q_base+8'h00]), 32'd0);
    check_val("ones_cin_0f", 32'(q_cin[q_base+8'h0F]), 32'd4);
    check_val("ones_cin_ff", 32'(q_cin[q_base+8'hFF]), 32'd8);
    check_val("ones_cin_7ff", 32'(q_cin[q_base+11'h7FF]), 32'd8);
    check_val("lut_valid_holds", 32'(lut_valid), 32'd1);
`ifdef LUT_CHECKSUM_EN
    check_val("ones_csum", 32'(lut_csum), 32'h002000);
`endif

    for (int i = 0; i < 64; i++) cur_taps[i] = 16'd0;
    cur_taps[0] = 16'h8000;
    run_load(25);
    check_val("neg_tap_odd", 32'(q_cin[q_base+1]), 32'h000F8000);
    check_val("neg_tap_even", 32'(q_cin[q_base+2]), 32'd0);

    for (int i = 0; i < 64; i++) cur_taps[i] = 16'h7FFF;
    run_load(0);
    check_val("max_pos_ff", 32'(q_cin[q_base+255]), 32'h0003FFF8);
    for (int i = 0; i < 64; i++) cur_taps[i] = 16'h8000;
    run_load(10);
    check_val("max_neg_ff", 32'(q_cin[q_base+255]), 32'h000C0000);

    for (int i = 0; i < 64; i++) cur_taps[i] = 16'(i);
    run_load(40);
    check_val("index_caddr_503", 32'(q_addr[q_base+11'h503]), 32'h503);
    check_val("index_cin_503", 32'(q_cin[q_base+11'h503]), 32'd81);

    rand_taps();
    run_load(50);
    rand_taps();
    run_load(0);

    // Abort in the middle of group 2's writes
    rand_taps();
    pulse_start();
    feed(24, 30);
    wait_write(11'h264, 1'b0, found);
    @(posedge clk); #1;
    pulse_start();
    check_val("abort_cload_low", 32'(CLOAD), 32'd0);
    check_val("abort_caddr_held", 32'(CADDR), 32'h265);
    rand_taps();
    feed(64, 20);
    wait_done(400);
    verify_load();

    // Asynchronous reset while group 1 is being written
    rand_taps();
    pulse_start();
    feed(16, 0);
    wait_write(11'h100, 1'b1, found);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_coef_ready", 32'(coef_ready), 32'd0);
    check_val("mid_rst_cload", 32'(CLOAD), 32'd0);
    check_val("mid_rst_cin", 32'(CIN), 32'd0);
    check_val("mid_rst_caddr", 32'(CADDR), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_load_done", 32'(load_done), 32'd0);
    check_val("mid_rst_lut_valid", 32'(lut_valid), 32'd0);
`ifdef LUT_CHECKSUM_EN
    check_val("mid_rst_csum", 32'(lut_csum), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    rand_taps();
    run_load(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
